// File: rtl/lfsr_opgen.sv
// Pseudo-random operand generator: a 16-bit Fibonacci LFSR drives ain/bin/cin for a 16-bit adder.
// Latency: first vector valid one cycle after start is sampled; one vector per cycle with ready high.
// Backpressure: vec_ready low stalls the LFSR, the count and all outputs until the vector is taken.
module lfsr_opgen #(
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter int unsigned NUM_VEC = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        seed_load,
  input  logic [15:0] seed_in,
  input  logic        vec_ready,
  output logic        vec_valid,
  output logic [15:0] ain,
  output logic [15:0] bin,
  output logic        cin,
  output logic        busy,
  output logic        done,
  output logic [15:0] vec_cnt
);

  localparam logic [15:0] LAST_CNT = NUM_VEC[15:0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] lfsr;
  logic [15:0] lfsr_next;
  logic [15:0] cnt_next;
  logic [15:0] seed_safe;

  // Next-value helpers: one LFSR step, the incremented count, and a seed that can never be zero.
  always_comb begin
    lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    cnt_next  = vec_cnt + 16'd1;
    seed_safe = (seed_in == 16'd0) ? SEED : seed_in;
  end

  // Run control FSM with registered status outputs; the LFSR only moves on an accepted transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lfsr      <= SEED;
      vec_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      vec_cnt   <= 16'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // A seed load wins over start; a held start is then taken on the following cycle.
          if (seed_load) begin
            lfsr <= seed_safe;
          end else if (start) begin
            state     <= RUN;
            vec_cnt   <= 16'd0;
            vec_valid <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
          end
        end
        RUN: begin
          if (vec_ready) begin
            lfsr    <= lfsr_next;
            vec_cnt <= cnt_next;
            if (cnt_next == LAST_CNT) begin
              state     <= DONE;
              vec_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          vec_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

  // Operands are pure functions of the LFSR register, so they hold whenever it holds.
  always_comb begin
    ain = lfsr;
    bin = {lfsr[7:0], lfsr[15:8]} ^ 16'h5A5A;
    cin = lfsr[15] ^ lfsr[0];
  end

endmodule

// File: tb/tb_lfsr_opgen.sv
// Directed bench for lfsr_opgen: a 4-vector instance for control/seed/stall cases
// and a default 256-vector instance checked vector by vector against a reference sequence.
module tb_lfsr_opgen;

  logic        clk = 1'b0;
  logic        rst_n;
  // small instance (NUM_VEC=4)
  logic        start, seed_load, vec_ready;
  logic [15:0] seed_in;
  logic        vec_valid, cin, busy, done;
  logic [15:0] ain, bin, vec_cnt;
  // full-size instance (NUM_VEC=256)
  logic        start2, seed_load2, vec_ready2;
  logic [15:0] seed_in2;
  logic        vec_valid2, cin2, busy2, done2;
  logic [15:0] ain2, bin2, vec_cnt2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lfsr_opgen #(.SEED(16'hACE1), .NUM_VEC(4)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start), .seed_load(seed_load), .seed_in(seed_in),
    .vec_ready(vec_ready), .vec_valid(vec_valid), .ain(ain), .bin(bin), .cin(cin),
    .busy(busy), .done(done), .vec_cnt(vec_cnt)
  );

  lfsr_opgen u_full (
    .clk(clk), .rst_n(rst_n), .start(start2), .seed_load(seed_load2), .seed_in(seed_in2),
    .vec_ready(vec_ready2), .vec_valid(vec_valid2), .ain(ain2), .bin(bin2), .cin(cin2),
    .busy(busy2), .done(done2), .vec_cnt(vec_cnt2)
  );

  // Reference sequence generator for the long run.
  function automatic logic [15:0] ref_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] exp_seq [4];
  logic [15:0] m;

  initial begin
    exp_seq[0] = 16'hACE1; exp_seq[1] = 16'h59C3; exp_seq[2] = 16'hB387; exp_seq[3] = 16'h670F;
    rst_n = 1'b0;
    start = 1'b0; seed_load = 1'b0; seed_in = 16'd0; vec_ready = 1'b0;
    start2 = 1'b0; seed_load2 = 1'b0; seed_in2 = 16'd0; vec_ready2 = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // 1: reset values, then a reset asserted in the middle of a run
    check("rst_ain", ain, 16'hACE1);
    check("rst_bin", bin, 16'hBBF6);
    check("rst_cin", cin, 1'b0);
    check("rst_valid", vec_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_cnt", vec_cnt, 16'd0);
    start = 1'b1; vec_ready = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    check("pre_rst_ain", ain, 16'hB387);
    check("pre_rst_cnt", vec_cnt, 16'd2);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ain", ain, 16'hACE1);
    check("midrst_valid", vec_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_cnt", vec_cnt, 16'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // 4 (IDLE part): seed loads, including zero substitution
    seed_load = 1'b1; seed_in = 16'h0001;
    tick();
    check("seed1_ain", ain, 16'h0001);
    check("seed1_bin", bin, 16'h5B5A);
    check("seed1_cin", cin, 1'b1);
    seed_in = 16'h0000;
    tick();
    seed_load = 1'b0;
    check("seed0_ain", ain, 16'hACE1);

    // 2: four-vector run with ready high
    start = 1'b1; vec_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("run_valid%0d", i), vec_valid, 1'b1);
      check($sformatf("run_ain%0d", i), ain, exp_seq[i]);
      check($sformatf("run_cnt%0d", i), vec_cnt, i);
      tick();
    end
    check("end_done", done, 1'b1);
    check("end_cnt", vec_cnt, 16'd4);
    check("end_valid", vec_valid, 1'b0);
    check("end_busy", busy, 1'b0);
    tick();
    check("end_valid_hold", vec_valid, 1'b0);
    check("end_ain_hold", ain, 16'hCE1E);

    // 5: restart from DONE continues from the current LFSR
    start = 1'b1; vec_ready = 1'b0;
    tick();
    start = 1'b0;
    check("restart_cnt", vec_cnt, 16'd0);
    check("restart_done", done, 1'b0);
    check("restart_ain", ain, 16'hCE1E);

    // 3: backpressure for five cycles, then exactly one step
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("stall_ain%0d", i), ain, 16'hCE1E);
      check($sformatf("stall_bin%0d", i), bin, 16'h4494);
      check($sformatf("stall_cin%0d", i), cin, 1'b1);
      check($sformatf("stall_cnt%0d", i), vec_cnt, 16'd0);
    end
    vec_ready = 1'b1;
    tick();
    vec_ready = 1'b0;
    check("unstall_ain", ain, 16'h9C3C);
    check("unstall_cnt", vec_cnt, 16'd1);
    tick();
    check("unstall_hold", ain, 16'h9C3C);

    // 4 (RUN part): seed_load is ignored while running
    seed_load = 1'b1; seed_in = 16'h1234;
    tick();
    seed_load = 1'b0;
    check("runseed_ain", ain, 16'h9C3C);
    check("runseed_busy", busy, 1'b1);
    vec_ready = 1'b1;
    repeat (3) tick();
    vec_ready = 1'b0;
    check("run2_done", done, 1'b1);
    check("run2_cnt", vec_cnt, 16'd4);

    // 4 (DONE part): zero seed, seed priority over start
    seed_load = 1'b1; seed_in = 16'h0000;
    tick();
    check("doneseed0_ain", ain, 16'hACE1);
    check("doneseed0_done", done, 1'b1);
    seed_in = 16'hBEEF; start = 1'b1;
    tick();
    check("prio_ain", ain, 16'hBEEF);
    check("prio_done", done, 1'b1);
    check("prio_busy", busy, 1'b0);
    seed_load = 1'b0;
    tick();
    start = 1'b0;
    check("prio_run_busy", busy, 1'b1);
    check("prio_run_cnt", vec_cnt, 16'd0);
    check("prio_run_ain", ain, 16'hBEEF);

    // 6: full 256-vector run with ready tied high, every vector against the reference
    start2 = 1'b1; vec_ready2 = 1'b1;
    tick();
    start2 = 1'b0;
    m = 16'hACE1;
    for (int i = 0; i < 256; i++) begin
      check($sformatf("full_valid%0d", i), vec_valid2, 1'b1);
      check($sformatf("full_ain%0d", i), ain2, m);
      check($sformatf("full_bin%0d", i), bin2, {m[7:0], m[15:8]} ^ 16'h5A5A);
      check($sformatf("full_cin%0d", i), cin2, m[15] ^ m[0]);
      check($sformatf("full_sum%0d", i), {15'd0, ain2} + {15'd0, bin2} + {30'd0, cin2},
            {15'd0, m} + {15'd0, {m[7:0], m[15:8]} ^ 16'h5A5A} + {30'd0, m[15] ^ m[0]});
      m = ref_step(m);
      tick();
    end
    check("full_done", done2, 1'b1);
    check("full_cnt", vec_cnt2, 16'd256);
    check("full_valid_end", vec_valid2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
